// File: rtl/duck_sprite_indexer_pkg.sv
// rtl/duck_sprite_indexer_pkg.sv - shared types and geometry constants for the duck sprite indexer
package duck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    HIT  = 2'd2,
    FALL = 2'd3
  } duck_state_t;

  localparam int SPRITE_W   = 32;
  localparam int SPRITE_H   = 32;
  localparam int NUM_FRAMES = 3;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  // ROM holds every flying frame plus one hit/fall pose after them
  localparam int ADDR_W  = $clog2((NUM_FRAMES + 1) * SPRITE_W * SPRITE_H);
  localparam int FRAME_W = $clog2(NUM_FRAMES + 1);

  localparam logic [3:0] TRANSPARENT = 4'h0;

endpackage

// File: rtl/duck_sprite_indexer_if.sv
// rtl/duck_sprite_indexer_if.sv - per-pixel bus between VGA scan, sprite ROM and palette
interface duck_sprite_indexer_if;
  import duck_pkg::*;

  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        palette_index;
  logic              pixel_on;

  // scan/ROM side: supplies the pixel coordinate and ROM data
  modport master (
    output draw_x, draw_y, rom_q,
    input  rom_addr, palette_index, pixel_on
  );

  // indexer side: turns coordinates into ROM address and palette index
  modport slave (
    input  draw_x, draw_y, rom_q,
    output rom_addr, palette_index, pixel_on
  );

endinterface

// File: rtl/duck_pixel_pipe.sv
// rtl/duck_pixel_pipe.sv - two-stage pixel path: box test, mirror, ROM address, palette output
module duck_pixel_pipe
  import duck_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  duck_state_t           state,
  input  logic [9:0]            duck_x,
  input  logic [9:0]            duck_y,
  input  logic                  dir,
  input  logic [FRAME_W-1:0]    frame,
  duck_sprite_indexer_if.slave  pix
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);

  logic [9:0]        dx;
  logic [9:0]        dy;
  logic              in_box;
  logic [XB-1:0]     dx_m;
  logic [ADDR_W-1:0] addr_c;
  logic              in_box_d;

  // c0: sprite-relative offsets; a pixel left/above the duck wraps large and falls outside the box
  always_comb begin
    dx     = pix.draw_x - duck_x;
    dy     = pix.draw_y - duck_y;
    in_box = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H)) && (state != IDLE);
    dx_m   = dir ? dx[XB-1:0] : XB'(SPRITE_W - 1) - dx[XB-1:0];
    addr_c = '0;
    if (in_box) begin
      addr_c = ADDR_W'(frame) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(dy[YB-1:0]) * ADDR_W'(SPRITE_W)
             + ADDR_W'(dx_m);
    end
  end

  // c1: register ROM address and carry the box flag alongside the ROM read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix.rom_addr <= '0;
      in_box_d     <= 1'b0;
    end else begin
      pix.rom_addr <= addr_c;
      in_box_d     <= in_box;
    end
  end

  // c2: gate ROM data with the delayed box flag; index 0 is see-through
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix.palette_index <= TRANSPARENT;
      pix.pixel_on      <= 1'b0;
    end else begin
      pix.palette_index <= in_box_d ? pix.rom_q : TRANSPARENT;
      pix.pixel_on      <= in_box_d && (pix.rom_q != TRANSPARENT);
    end
  end

endmodule

// File: rtl/duck_sprite_indexer.sv
// rtl/duck_sprite_indexer.sv - duck motion FSM, animation and hit hold, feeding the pixel pipe
module duck_sprite_indexer
  import duck_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 6,
  parameter int SPEED           = 2,
  parameter int FALL_SPEED      = 3,
  parameter int HIT_HOLD        = 30
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 spawn,
  input  logic [9:0]           spawn_x,
  input  logic [9:0]           spawn_y,
  input  logic                 spawn_dir,
  input  logic                 shot,
  duck_sprite_indexer_if.slave pix,
  output logic [9:0]           duck_x,
  output logic [9:0]           duck_y,
  output logic [1:0]           duck_state,
  output logic                 escaped,
  output logic                 fallen
);

  localparam int ANIM_W = $clog2(TICKS_PER_FRAME);
  localparam int HOLD_W = $clog2(HIT_HOLD + 1);

  duck_state_t          state;
  logic                 dir;
  logic [ANIM_W-1:0]    anim_cnt;
  logic [FRAME_W-1:0]   frame;
  logic [HOLD_W-1:0]    hold;
  logic [10:0]          x_right;
  logic                 exit_fly;
  logic                 land;
  logic [FRAME_W-1:0]   pipe_frame;

  // edge tests use the current position, so an exiting duck is not moved on that tick
  always_comb begin
    x_right    = {1'b0, duck_x} + 11'(SPRITE_W + SPEED);
    exit_fly   = (duck_y < 10'(SPEED))
              || (!dir && (duck_x < 10'(SPEED)))
              || (dir && (x_right > 11'(SCREEN_W)));
    land       = ({1'b0, duck_y} + 11'(SPRITE_H + FALL_SPEED)) >= 11'(SCREEN_H);
    pipe_frame = ((state == HIT) || (state == FALL)) ? FRAME_W'(NUM_FRAMES) : frame;
  end

  // motion/animation FSM; everything visible moves only on frame_tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      duck_x   <= '0;
      duck_y   <= '0;
      dir      <= 1'b0;
      anim_cnt <= '0;
      frame    <= '0;
      hold     <= '0;
      escaped  <= 1'b0;
      fallen   <= 1'b0;
    end else begin
      escaped <= 1'b0;
      fallen  <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn) begin
            duck_x   <= spawn_x;
            duck_y   <= spawn_y;
            dir      <= spawn_dir;
            anim_cnt <= '0;
            frame    <= '0;
            state    <= FLY;
          end
        end
        FLY: begin
          if (shot) begin
            hold  <= HOLD_W'(HIT_HOLD);
            state <= HIT;
          end else if (frame_tick) begin
            if (exit_fly) begin
              escaped <= 1'b1;
              state   <= IDLE;
            end else begin
              duck_x <= dir ? duck_x + 10'(SPEED) : duck_x - 10'(SPEED);
              duck_y <= duck_y - 10'(SPEED);
              if (anim_cnt == ANIM_W'(TICKS_PER_FRAME - 1)) begin
                anim_cnt <= '0;
                frame    <= (frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame + FRAME_W'(1);
              end else begin
                anim_cnt <= anim_cnt + ANIM_W'(1);
              end
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            hold <= hold - HOLD_W'(1);
            if (hold <= HOLD_W'(1)) state <= FALL;
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (land) begin
              duck_y <= 10'(SCREEN_H - SPRITE_H);
              fallen <= 1'b1;
              state  <= IDLE;
            end else begin
              duck_y <= duck_y + 10'(FALL_SPEED);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign duck_state = state;

  duck_pixel_pipe u_pipe (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .state   (state),
    .duck_x  (duck_x),
    .duck_y  (duck_y),
    .dir     (dir),
    .frame   (pipe_frame),
    .pix     (pix)
  );

endmodule

// File: tb/tb_duck_sprite_indexer.sv
// tb/tb_duck_sprite_indexer.sv - directed self-checking bench for duck_sprite_indexer
module tb_duck_sprite_indexer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, spawn, spawn_dir, shot;
  logic [9:0] spawn_x, spawn_y;
  logic [9:0] duck_x, duck_y;
  logic [1:0] duck_state;
  logic       escaped, fallen;
  logic       rom_zero;

  int total = 0;
  int bad   = 0;
  int ym;
  int n;

  typedef struct {
    string       tag;
    logic [11:0] addr;
    logic [3:0]  pal;
    logic        on;
  } pix_exp_t;

  pix_exp_t sb[$];

  duck_sprite_indexer_if pix();

  duck_sprite_indexer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .spawn_dir  (spawn_dir),
    .shot       (shot),
    .pix        (pix),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .duck_state (duck_state),
    .escaped    (escaped),
    .fallen     (fallen)
  );

  // ROM model: data is a fixed function of the address presented the cycle before
  assign pix.rom_q = rom_zero ? 4'h0 : (pix.rom_addr[3:0] ^ 4'h5);

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_spawn(input logic [9:0] x, input logic [9:0] y, input logic d, input logic with_shot);
    spawn_x = x; spawn_y = y; spawn_dir = d;
    spawn = 1'b1; shot = with_shot;
    @(posedge Clk); #1;
    spawn = 1'b0; shot = 1'b0;
  endtask

  task automatic pix_chk(input string tag, input logic [9:0] px, input logic [9:0] py,
                         input logic ein, input logic [11:0] eaddr);
    pix_exp_t e;
    pix.draw_x = px;
    pix.draw_y = py;
    e.tag  = tag;
    e.addr = ein ? eaddr : 12'h0;
    e.pal  = (ein && !rom_zero) ? (e.addr[3:0] ^ 4'h5) : 4'h0;
    e.on   = (e.pal != 4'h0);
    sb.push_back(e);
    @(posedge Clk); #1;
    chk({tag, "_addr"}, 32'(pix.rom_addr), 32'(sb[0].addr));
    @(posedge Clk); #1;
    e = sb.pop_front();
    chk({e.tag, "_pal"}, 32'(pix.palette_index), 32'(e.pal));
    chk({e.tag, "_on"}, 32'(pix.pixel_on), 32'(e.on));
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; spawn = 1'b0; shot = 1'b0;
    spawn_x = '0; spawn_y = '0; spawn_dir = 1'b0; rom_zero = 1'b0;
    pix.draw_x = '0; pix.draw_y = '0;
    repeat (2) @(posedge Clk); #1;
    chk("rst_state", 32'(duck_state), 0);
    chk("rst_x", 32'(duck_x), 0);
    chk("rst_y", 32'(duck_y), 0);
    chk("rst_pixel_on", 32'(pix.pixel_on), 0);
    chk("rst_rom_addr", 32'(pix.rom_addr), 0);
    chk("rst_escaped", 32'(escaped), 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // spawn with a same-cycle shot: spawn wins
    do_spawn(10'd100, 10'd300, 1'b1, 1'b1);
    chk("spawn_state", 32'(duck_state), 1);
    chk("spawn_x", 32'(duck_x), 100);
    chk("spawn_y", 32'(duck_y), 300);
    pix_chk("f0_dir1", 10'd103, 10'd302, 1'b1, 12'd67);
    rom_zero = 1'b1;
    pix_chk("f0_q0", 10'd103, 10'd302, 1'b1, 12'd67);
    rom_zero = 1'b0;

    // animation steps only after six ticks
    repeat (5) tick();
    pix_chk("f0_tick5", 10'd113, 10'd292, 1'b1, 12'd67);
    tick();
    chk("fly6_x", 32'(duck_x), 112);
    chk("fly6_y", 32'(duck_y), 288);
    pix_chk("f1_tick6", 10'd115, 10'd290, 1'b1, 12'd1091);
    pix_chk("wrap_left", 10'd111, 10'd290, 1'b0, 12'd0);

    // shot beats a same-cycle tick
    shot = 1'b1; frame_tick = 1'b1;
    @(posedge Clk); #1;
    shot = 1'b0; frame_tick = 1'b0;
    chk("hit_state", 32'(duck_state), 2);
    chk("hit_x", 32'(duck_x), 112);
    chk("hit_y", 32'(duck_y), 288);
    pix_chk("hit_frame", 10'd115, 10'd290, 1'b1, 12'd3139);

    // hold of 30 ticks; a second shot must not restart it
    repeat (10) tick();
    shot = 1'b1;
    @(posedge Clk); #1;
    shot = 1'b0;
    repeat (19) tick();
    chk("hit_29", 32'(duck_state), 2);
    tick();
    chk("fall_state", 32'(duck_state), 3);
    chk("fall_y0", 32'(duck_y), 288);

    do_spawn(10'd5, 10'd5, 1'b1, 1'b0);
    chk("fall_spawn_ign", 32'(duck_state), 3);
    chk("fall_spawn_x", 32'(duck_x), 112);

    ym = 288;
    n  = 0;
    while ((ym + 32 + 3 < 480) && (n < 200)) begin
      tick();
      ym += 3;
      n++;
    end
    chk("fall_pre_y", 32'(duck_y), 32'(ym));
    chk("fall_pre_state", 32'(duck_state), 3);
    chk("fall_pre_fallen", 32'(fallen), 0);
    tick();
    chk("fallen_pulse", 32'(fallen), 1);
    chk("fallen_state", 32'(duck_state), 0);
    chk("fallen_y", 32'(duck_y), 448);
    @(posedge Clk); #1;
    chk("fallen_clear", 32'(fallen), 0);
    pix_chk("idle_px", 10'd115, 10'd450, 1'b0, 12'd0);

    // left-flying duck is mirrored
    do_spawn(10'd200, 10'd200, 1'b0, 1'b0);
    pix_chk("dir0", 10'd203, 10'd202, 1'b1, 12'd92);
    pix_chk("dir0_edge", 10'd231, 10'd202, 1'b1, 12'd64);
    pix_chk("dir0_out", 10'd232, 10'd202, 1'b0, 12'd0);

    // asynchronous reset in the middle of flight
    pix_chk("pre_rst", 10'd203, 10'd202, 1'b1, 12'd92);
    Reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(duck_state), 0);
    chk("arst_x", 32'(duck_x), 0);
    chk("arst_y", 32'(duck_y), 0);
    chk("arst_pixel_on", 32'(pix.pixel_on), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // right edge: 606 still moves, 608 escapes without moving
    do_spawn(10'd606, 10'd300, 1'b1, 1'b0);
    tick();
    chk("esc_r_x1", 32'(duck_x), 608);
    chk("esc_r_noesc", 32'(escaped), 0);
    tick();
    chk("esc_r_pulse", 32'(escaped), 1);
    chk("esc_r_state", 32'(duck_state), 0);
    chk("esc_r_x", 32'(duck_x), 608);
    @(posedge Clk); #1;
    chk("esc_r_clear", 32'(escaped), 0);

    // left edge
    do_spawn(10'd3, 10'd300, 1'b0, 1'b0);
    tick();
    chk("esc_l_x1", 32'(duck_x), 1);
    chk("esc_l_y1", 32'(duck_y), 298);
    tick();
    chk("esc_l_pulse", 32'(escaped), 1);
    chk("esc_l_state", 32'(duck_state), 0);
    chk("esc_l_x", 32'(duck_x), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
